serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_full_sub.sv | 16 +
 rtl/serial_subtractor.sv | 94 +++++++++
 tb/tb_serial_subtractor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sub_state_t;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full-subtractor cell used by the serial datapath.
module full_subtractor (
  output logic d,
  output logic bout,
  input  logic x,
  input  logic y,
  input  logic bin
);

  logic xy_x;

  assign xy_x = x ^ y;
  assign d    = xy_x ^ bin;
  assign bout = (~x & y) | (~xy_x & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0] cnt;
  logic d;
  logic bout;

  // borrow doubles as the borrow flop; it ends holding the final borrow
  full_subtractor u_cell (
    .d    (d),
    .bout (bout),
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      sa     <= '0;
      sb     <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= S_RUN;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_RUN: begin
          diff   <= {d, diff[WIDTH-1:1]};
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          borrow <= bout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= borrow ^ bout;
`endif
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Honours SERIAL_SUB_OVF_EN when defined.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic busy;
  logic done;
  logic [W-1:0] diff;
  logic borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < 30 && !ok) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic [W-1:0] ed,
                        input logic eb, input logic eo);
    int n;
    bit ok;
    a = xa;
    b = xb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(n, ok);
    chk({tag, "_lat"}, 32'(n + 1), 32'd9);
    chk({tag, "_diff"}, 32'(diff), 32'(ed));
    chk({tag, "_borrow"}, 32'(borrow), 32'(eb));
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo) ;
`endif
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(diff), 32'(ed));
  endtask

  logic [W-1:0] ops_a [5] = '{8'h5A, 8'h00, 8'h80, 8'h7F, 8'h12};
  logic [W-1:0] ops_b [5] = '{8'h3C, 8'h01, 8'h01, 8'hFF, 8'h34};
  logic [W-1:0] exp_d [4] = '{8'h1E, 8'hFF, 8'h7F, 8'h80};

  initial begin
    int n;
    int dones;
    int nxt;
    bit ok;
    logic [W-1:0] seen;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif

    run_op("5a_3c", 8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0);
    run_op("00_01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    run_op("80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("7f_ff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
`endif

    // start during RUN must be ignored
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF;
    b = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        seen = diff;
      end
    end
    chk("ign_dones", 32'(dones), 32'd1);
    chk("ign_diff", 32'(seen), 32'h0F);

    // reset mid-run aborts
    a = 8'h5A;
    b = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("abort_nodone", 32'(dones), 32'd0);
    run_op("03_02", 8'h03, 8'h02, 8'h01, 1'b0, 1'b0);

    // reset wins over start
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("rst_start_idle", 32'(busy), 32'd0);

    // back-to-back with start held high
    a = ops_a[0];
    b = ops_b[0];
    start = 1'b1;
    nxt = 1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      ok = 1'b0;
      while (n < 30 && !ok) begin
        @(negedge clk);
        n++;
        if (n == 1 && nxt < 5) begin
          a = ops_a[nxt];
          b = ops_b[nxt];
          nxt++;
        end
        if (done === 1'b1) ok = 1'b1;
      end
      chk($sformatf("b2b%0d_period", i), 32'(n), 32'd9);
      chk($sformatf("b2b%0d_diff", i), 32'(diff), 32'(exp_d[i]));
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(n, ok);
    chk("b2b_last", 32'(diff), 32'hDE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
